maxpool_scan_ctrl: RTL



---
 rtl/maxpool_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/maxpool_scan_ctrl.sv
// Walks every pooling window of one feature map, issuing one feature-buffer read per cycle;
// output coordinates trail the address by one cycle to match the buffer's read latency.
module maxpool_scan_ctrl #(
  parameter int datai_width  = 4,
  parameter int datai_height = 4,
  parameter int kernel_width  = 2,
  parameter int kernel_height = 2,
  parameter int stride        = 2,
  parameter int addr_width    = 8,
  parameter int datao_width   = ((datai_width - kernel_width) / stride) + 1,
  parameter int datao_height  = ((datai_height - kernel_height) / stride) + 1
) (
  input  logic                  clk_en,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [addr_width-1:0] rd_addr,
  output logic                  pool_on,
  output logic                  part_fin,
  output logic                  turn_fin,
  output logic [3:0]            resu_l,
  output logic [3:0]            resu_c
);

  localparam int KCW = (kernel_width > 1) ? $clog2(kernel_width) : 1;
  localparam int KRW = (kernel_height > 1) ? $clog2(kernel_height) : 1;
  localparam int AW  = addr_width + 4;

  localparam logic [KCW-1:0] KC_LAST  = KCW'(kernel_width - 1);
  localparam logic [KRW-1:0] KR_LAST  = KRW'(kernel_height - 1);
  localparam logic [3:0]     OC_LAST  = 4'(datao_width - 1);
  localparam logic [3:0]     OL_LAST  = 4'(datao_height - 1);
  localparam logic [AW-1:0]  STRIDE_W = AW'(stride);
  localparam logic [AW-1:0]  ROW_W    = AW'(datai_width);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, FIN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     ol_q, ol_d, oc_q, oc_d;
  logic [KRW-1:0] kr_q, kr_d;
  logic [KCW-1:0] kc_q, kc_d;
  logic [3:0]     resu_l_q, resu_l_d, resu_c_q, resu_c_d;
  logic [AW-1:0]  row_a, col_a;

  always_ff @(posedge clk_en) begin
    if (reset) begin
      state_q  <= IDLE;
      ol_q     <= '0;
      oc_q     <= '0;
      kr_q     <= '0;
      kc_q     <= '0;
      resu_l_q <= '0;
      resu_c_q <= '0;
    end else begin
      state_q  <= state_d;
      ol_q     <= ol_d;
      oc_q     <= oc_d;
      kr_q     <= kr_d;
      kc_q     <= kc_d;
      resu_l_q <= resu_l_d;
      resu_c_q <= resu_c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ol_d     = ol_q;
    oc_d     = oc_q;
    kr_d     = kr_q;
    kc_d     = kc_q;
    resu_l_d = resu_l_q;
    resu_c_d = resu_c_q;
    case (state_q)
      IDLE: begin
        ol_d = '0;
        oc_d = '0;
        kr_d = '0;
        kc_d = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (!hold) begin
          // Coordinates of this read land on the buffer output next cycle.
          resu_l_d = ol_q;
          resu_c_d = oc_q;
          if (kc_q != KC_LAST) begin
            kc_d = kc_q + 1'b1;
          end else begin
            kc_d = '0;
            if (kr_q != KR_LAST) begin
              kr_d = kr_q + 1'b1;
            end else begin
              kr_d = '0;
              if (oc_q != OC_LAST) begin
                oc_d = oc_q + 4'd1;
              end else begin
                oc_d = '0;
                if (ol_q != OL_LAST) begin
                  ol_d = ol_q + 4'd1;
                end else begin
                  ol_d    = '0;
                  state_d = FLUSH;
                end
              end
            end
          end
        end
      end
      FLUSH: begin
        if (!hold) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_a = AW'(ol_q) * STRIDE_W + AW'(kr_q);
  assign col_a = AW'(oc_q) * STRIDE_W + AW'(kc_q);

  assign rd_addr  = (state_q == SCAN) ? addr_width'(row_a * ROW_W + col_a) : '0;
  assign rd_en    = (state_q == SCAN) && !hold;
  assign part_fin = (state_q == SCAN) && (kr_q == '0) && (kc_q == '0);
  assign busy     = (state_q != IDLE);
  assign pool_on  = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign turn_fin = (state_q == FIN);
  assign resu_l   = resu_l_q;
  assign resu_c   = resu_c_q;

endmodule
